mmio_bus_ctrl: RTL and testbench



---
 rtl/mmio_bus_ctrl_pkg.sv | 23 ++
 rtl/mmio_addr_decode.sv | 22 ++
 rtl/mmio_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_bus_ctrl_pkg.sv
// Shared encodings and default device addresses for the MMIO bus controller
// and anything else that needs to classify CPU addresses.
package mmio_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        TGT_RAM       = 2'b00,
        TGT_VGA       = 2'b01,
        TGT_UART_DATA = 2'b10,
        TGT_UART_STAT = 2'b11
    } target_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_TX_WAIT,
        ST_RESP
    } state_e;

    localparam logic [15:0] DEF_UART_DATA_ADDR = 16'hBF00;
    localparam logic [15:0] DEF_UART_STAT_ADDR = 16'hBF01;
    localparam logic [15:0] DEF_VGA_ADDR       = 16'hBF0A;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational address-to-target classifier; exact matches pick a device,
// everything else falls through to RAM.
module mmio_addr_decode
    import mmio_bus_ctrl_pkg::*;
#(
    parameter int                  ADDR_W         = 16,
    parameter logic [ADDR_W-1:0]   UART_DATA_ADDR = DEF_UART_DATA_ADDR,
    parameter logic [ADDR_W-1:0]   UART_STAT_ADDR = DEF_UART_STAT_ADDR,
    parameter logic [ADDR_W-1:0]   VGA_ADDR       = DEF_VGA_ADDR
) (
    input  logic [ADDR_W-1:0] addr_i,
    output target_e           target_o
);

    always_comb begin
        target_o = TGT_RAM;
        if (addr_i == UART_DATA_ADDR)      target_o = TGT_UART_DATA;
        else if (addr_i == UART_STAT_ADDR) target_o = TGT_UART_STAT;
        else if (addr_i == VGA_ADDR)       target_o = TGT_VGA;
    end

endmodule

// File: rtl/mmio_bus_ctrl.sv
// Single-outstanding MMIO controller: accepts one CPU request in IDLE, runs
// the RAM wait states or UART/VGA handshake, then strobes a one-cycle response.
module mmio_bus_ctrl
    import mmio_bus_ctrl_pkg::*;
#(
    parameter int                ADDR_W         = 16,
    parameter int                DATA_W         = 16,
    parameter logic [ADDR_W-1:0] UART_DATA_ADDR = DEF_UART_DATA_ADDR,
    parameter logic [ADDR_W-1:0] UART_STAT_ADDR = DEF_UART_STAT_ADDR,
    parameter logic [ADDR_W-1:0] VGA_ADDR       = DEF_VGA_ADDR,
    parameter int                RAM_WAIT       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_avail,
    output logic              uart_rx_pop,
    input  logic              uart_tx_ready,
    output logic [7:0]        uart_tx_data,
    output logic              uart_tx_push,
    output logic              vga_we,
    output logic [DATA_W-1:0] vga_data
);

    state_e            state_q;
    target_e           tgt;
    logic [3:0]        cnt_q;
    logic [7:0]        tx_byte_q;
    logic [DATA_W-1:0] vga_shadow_q;
    logic              rsp_valid_q, uart_rx_pop_q, vga_we_q;
    logic              ram_en_q, ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q, rsp_rdata_q;
    logic [DATA_W-1:0] rx_ext, stat_ext;

    mmio_addr_decode #(
        .ADDR_W        (ADDR_W),
        .UART_DATA_ADDR(UART_DATA_ADDR),
        .UART_STAT_ADDR(UART_STAT_ADDR),
        .VGA_ADDR      (VGA_ADDR)
    ) u_dec (
        .addr_i  (req_addr),
        .target_o(tgt)
    );

    // Zero-extension written this way so DATA_W == 8 needs no zero-width replication.
    always_comb begin
        rx_ext        = '0;
        rx_ext[7:0]   = uart_rx_data;
        stat_ext      = '0;
        stat_ext[1:0] = {uart_rx_avail, uart_tx_ready};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_byte_q     <= '0;
            vga_shadow_q  <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            uart_rx_pop_q <= 1'b0;
            vga_we_q      <= 1'b0;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
        end else begin
            rsp_valid_q   <= 1'b0;
            uart_rx_pop_q <= 1'b0;
            vga_we_q      <= 1'b0;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    tx_byte_q <= req_wdata[7:0];
                    case (tgt)
                        TGT_RAM: begin
                            ram_en_q    <= 1'b1;
                            ram_we_q    <= req_we;
                            ram_addr_q  <= req_addr;
                            ram_wdata_q <= req_wdata;
                            cnt_q       <= 4'(RAM_WAIT);
                            state_q     <= ST_RAM_ACC;
                        end
                        TGT_UART_DATA: begin
                            if (req_we) begin
                                state_q <= ST_TX_WAIT;
                            end else begin
                                // Non-blocking read: empty receiver returns 0 and pops nothing.
                                rsp_valid_q   <= 1'b1;
                                rsp_rdata_q   <= uart_rx_avail ? rx_ext : '0;
                                uart_rx_pop_q <= uart_rx_avail;
                                state_q       <= ST_RESP;
                            end
                        end
                        TGT_UART_STAT: begin
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= req_we ? '0 : stat_ext;
                            state_q     <= ST_RESP;
                        end
                        default: begin
                            rsp_valid_q <= 1'b1;
                            if (req_we) begin
                                vga_we_q     <= 1'b1;
                                vga_shadow_q <= req_wdata;
                                rsp_rdata_q  <= '0;
                            end else begin
                                rsp_rdata_q  <= vga_shadow_q;
                            end
                            state_q <= ST_RESP;
                        end
                    endcase
                end
                ST_RAM_ACC: begin
                    if (cnt_q == 4'd0) begin
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= ram_we_q ? '0 : ram_rdata;
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_TX_WAIT: if (uart_tx_ready) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= '0;
                    state_q     <= ST_RESP;
                end
                default: begin
                    rsp_rdata_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    // Push must coincide with the cycle the transmitter reports ready, so it is decoded, not registered.
    assign uart_tx_push = rst && (state_q == ST_TX_WAIT) && uart_tx_ready;
    assign uart_tx_data = (state_q == ST_TX_WAIT) ? tx_byte_q : 8'h00;
    assign req_ready    = rst && (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign uart_rx_pop  = uart_rx_pop_q;
    assign vga_we       = vga_we_q;
    assign vga_data     = vga_shadow_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;

endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Directed bench for mmio_bus_ctrl with hand-computed expectations.
module tb_mmio_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_avail, uart_rx_pop, uart_tx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_push, vga_we;
    logic [15:0] vga_data;

    int n_cmp = 0;
    int n_err = 0;

    mmio_bus_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .uart_rx_data(uart_rx_data), .uart_rx_avail(uart_rx_avail), .uart_rx_pop(uart_rx_pop),
        .uart_tx_ready(uart_tx_ready), .uart_tx_data(uart_tx_data), .uart_tx_push(uart_tx_push),
        .vga_we(vga_we), .vga_data(vga_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic accept();
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        ram_rdata = '0; uart_rx_data = '0; uart_rx_avail = 1'b0; uart_tx_ready = 1'b0;
        tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_ramen", ram_en, 0);
        chk("rst_vgadata", vga_data, 0);
        chk("rst_rdata", rsp_rdata, 0);
        rst = 1'b1;
        #1;
        chk("idle_ready", req_ready, 1);

        // RAM read, RAM_WAIT=1: ram_en cycles 1-2, response cycle 3, ready cycle 4
        ram_rdata = 16'h1234;
        req(1'b0, 16'h0040, 16'h0);
        accept();
        chk("ram_rd_en_c1", ram_en, 1);
        chk("ram_rd_addr", ram_addr, 16'h0040);
        chk("ram_rd_we", ram_we, 0);
        chk("ram_rd_busy", req_ready, 0);
        tick();
        chk("ram_rd_en_c2", ram_en, 1);
        chk("ram_rd_norsp_c2", rsp_valid, 0);
        tick();
        chk("ram_rd_rspv_c3", rsp_valid, 1);
        chk("ram_rd_data", rsp_rdata, 16'h1234);
        chk("ram_rd_en_c3", ram_en, 0);
        tick();
        chk("ram_rd_rspv_c4", rsp_valid, 0);
        chk("ram_rd_ready_c4", req_ready, 1);

        // RAM write near the device window must still decode as RAM
        req(1'b1, 16'hBF02, 16'hBEEF);
        accept();
        chk("ram_wr_en", ram_en, 1);
        chk("ram_wr_we", ram_we, 1);
        chk("ram_wr_wdata", ram_wdata, 16'hBEEF);
        chk("ram_wr_addr", ram_addr, 16'hBF02);
        tick(); tick();
        chk("ram_wr_rspv", rsp_valid, 1);
        chk("ram_wr_rdata", rsp_rdata, 0);
        tick();

        // UART data read, byte available
        uart_rx_avail = 1'b1; uart_rx_data = 8'h5A;
        req(1'b0, 16'hBF00, 16'h0);
        accept();
        chk("rx_rspv", rsp_valid, 1);
        chk("rx_data", rsp_rdata, 16'h005A);
        chk("rx_pop", uart_rx_pop, 1);
        tick();
        chk("rx_pop_off", uart_rx_pop, 0);
        chk("rx_rspv_off", rsp_valid, 0);
        chk("rx_ready", req_ready, 1);

        // UART data read, nothing available
        uart_rx_avail = 1'b0;
        req(1'b0, 16'hBF00, 16'h0);
        accept();
        chk("rx_empty_rspv", rsp_valid, 1);
        chk("rx_empty_data", rsp_rdata, 0);
        chk("rx_empty_pop", uart_rx_pop, 0);
        tick();

        // Status reads
        uart_rx_avail = 1'b1; uart_tx_ready = 1'b0;
        req(1'b0, 16'hBF01, 16'h0);
        accept();
        chk("stat_rx", rsp_rdata, 16'h0002);
        chk("stat_rx_pop", uart_rx_pop, 0);
        tick();
        uart_rx_avail = 1'b0; uart_tx_ready = 1'b1;
        req(1'b0, 16'hBF01, 16'h0);
        accept();
        chk("stat_tx", rsp_rdata, 16'h0001);
        tick();
        uart_tx_ready = 1'b0;

        // UART write stalls while transmitter busy
        req(1'b1, 16'hBF00, 16'h0041);
        accept();
        for (int i = 0; i < 5; i++) begin
            chk("tx_stall_push", uart_tx_push, 0);
            chk("tx_stall_rspv", rsp_valid, 0);
            tick();
        end
        chk("tx_stall_ready", req_ready, 0);
        uart_tx_ready = 1'b1;
        #1;
        chk("tx_push", uart_tx_push, 1);
        chk("tx_data", uart_tx_data, 8'h41);
        tick();
        uart_tx_ready = 1'b0;
        chk("tx_push_once", uart_tx_push, 0);
        chk("tx_rspv", rsp_valid, 1);
        tick();
        chk("tx_done_ready", req_ready, 1);

        // VGA write then read back
        req(1'b1, 16'hBF0A, 16'hABCD);
        accept();
        chk("vga_we", vga_we, 1);
        chk("vga_data", vga_data, 16'hABCD);
        chk("vga_wr_rspv", rsp_valid, 1);
        tick();
        chk("vga_we_off", vga_we, 0);
        req(1'b0, 16'hBF0A, 16'h0);
        accept();
        chk("vga_rd", rsp_rdata, 16'hABCD);
        chk("vga_rd_we", vga_we, 0);
        tick();

        // Reset during RAM_ACC aborts without a response
        ram_rdata = 16'h7777;
        req(1'b0, 16'h0100, 16'h0);
        accept();
        rst = 1'b0;
        tick();
        chk("rstram_en", ram_en, 0);
        chk("rstram_rspv", rsp_valid, 0);
        chk("rstram_ready", req_ready, 0);
        rst = 1'b1;
        tick();
        chk("rstram_norsp", rsp_valid, 0);
        chk("rstram_idle", req_ready, 1);
        ram_rdata = 16'h5555;
        req(1'b0, 16'h0200, 16'h0);
        accept();
        tick(); tick();
        chk("post_rst_ram_rspv", rsp_valid, 1);
        chk("post_rst_ram_data", rsp_rdata, 16'h5555);
        tick();

        // Reset during TX_WAIT: no push even if ready appears with reset
        req(1'b1, 16'hBF00, 16'h00C3);
        accept();
        tick();
        rst = 1'b0; uart_tx_ready = 1'b1;
        #1;
        chk("rsttx_push_in_rst", uart_tx_push, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("rsttx_push", uart_tx_push, 0);
        chk("rsttx_rspv", rsp_valid, 0);
        chk("rsttx_txdata", uart_tx_data, 0);
        chk("rsttx_vga_cleared", vga_data, 0);
        req(1'b1, 16'hBF00, 16'h0099);
        accept();
        chk("post_rst_tx_push", uart_tx_push, 1);
        chk("post_rst_tx_data", uart_tx_data, 8'h99);
        tick();
        chk("post_rst_tx_rspv", rsp_valid, 1);
        uart_tx_ready = 1'b0;
        tick();
        chk("post_rst_tx_idle", req_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
